// File: rtl/pic_inta_sequencer.sv
// pic_inta_sequencer: 8259-style interrupt acknowledge sequencer.
// Resolves fully-nested priority (IR0 highest) of unmasked requests against
// the in-service register, raises INT, runs the two-pulse INTA handshake,
// sets the in-service bit, pulses `chosen` back to the request register and
// drives the vector byte {vector_base, level} during the second pulse.
// Optional feature macro: PIC_AUTO_EOI_EN adds the `aeoi` port; with aeoi=1
// the in-service bit is cleared when the second INTA rise is sampled.

module pic_inta_sequencer (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] IRR,
  input  logic [7:0] IMR,
  input  logic       INTA_n,
  input  logic [4:0] vector_base,
  input  logic       eoi_ns,
  input  logic       eoi_sp,
  input  logic [2:0] eoi_level,
`ifdef PIC_AUTO_EOI_EN
  input  logic       aeoi,
`endif
  output logic       INT,
  output logic [7:0] chosen,
  output logic [7:0] ISR,
  output logic [7:0] data_out,
  output logic       data_oe
);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StAck1,
    StGap,
    StAck2
  } state_e;

  state_e     state_q, state_d;
  logic       inta_q;
  logic [2:0] lvl_q, lvl_d;
  logic       spur_q, spur_d;
  logic       entry_q, entry_d;
  logic [7:0] chosen_q, chosen_d;
  logic [7:0] isr_q, isr_d;
  logic       int_q, int_d;
  logic       data_oe_q, data_oe_d;
  logic [7:0] data_out_q, data_out_d;

  logic [7:0] pend;
  logic [2:0] req_lvl;
  logic [3:0] isr_lvl;
  logic       eligible;
  logic       inta_fall;
  logic       inta_rise;
  logic       aeoi_en;
  logic       aeoi_clr;

`ifdef PIC_AUTO_EOI_EN
  assign aeoi_en = aeoi;
`else
  assign aeoi_en = 1'b0;
`endif

  // Edge detect on the CLK-synchronous acknowledge strobe.
  assign inta_fall = inta_q & ~INTA_n;
  assign inta_rise = ~inta_q & INTA_n;

  // Auto-EOI retires the level at the moment the second acknowledge ends.
  assign aeoi_clr  = aeoi_en && (state_q == StAck2) && inta_rise;

  // Priority resolution: lowest index wins; isr_lvl is 8 when nothing is in service.
  always_comb begin
    pend    = IRR & ~IMR;
    req_lvl = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (pend[i]) req_lvl = 3'(i);
    end
    isr_lvl = 4'd8;
    for (int i = 7; i >= 0; i--) begin
      if (isr_q[i]) isr_lvl = 4'(i);
    end
    eligible = (pend != 8'h00) && ({1'b0, req_lvl} < isr_lvl);
  end

  // Handshake FSM next state; the level is frozen on entry to the first acknowledge.
  always_comb begin
    state_d = state_q;
    lvl_d   = lvl_q;
    spur_d  = spur_q;
    entry_d = 1'b0;
    unique case (state_q)
      StIdle, StReq: begin
        if (inta_fall) begin
          // An acknowledge is honoured even without INT; no request means spurious IR7.
          state_d = StAck1;
          entry_d = 1'b1;
          if (pend != 8'h00) begin
            lvl_d  = req_lvl;
            spur_d = 1'b0;
          end else begin
            lvl_d  = 3'd7;
            spur_d = 1'b1;
          end
        end else if (eligible) begin
          state_d = StReq;
        end else begin
          state_d = StIdle;
        end
      end
      StAck1: begin
        if (inta_rise) state_d = StGap;
      end
      StGap: begin
        if (inta_fall) state_d = StAck2;
      end
      StAck2: begin
        if (inta_rise) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Registered outputs and in-service update: EOI first, then the acknowledge set.
  always_comb begin
    // INT only while the request is being held, so it drops on the same edge as the fall.
    int_d    = (state_q == StReq) && (state_d == StReq);
    chosen_d = 8'h00;
    isr_d    = isr_q;
    if (eoi_sp) begin
      isr_d[eoi_level] = 1'b0;
    end else if (eoi_ns && (isr_q != 8'h00)) begin
      isr_d[isr_lvl[2:0]] = 1'b0;
    end
    if (aeoi_clr) begin
      isr_d[lvl_q] = 1'b0;
    end
    if (entry_q && !spur_q) begin
      chosen_d[lvl_q] = 1'b1;
      isr_d[lvl_q]    = 1'b1;
    end
    data_oe_d  = (state_q == StAck2);
    data_out_d = data_oe_d ? {vector_base, lvl_q} : 8'h00;
  end

  // State and output registers with asynchronous active-high reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= StIdle;
      inta_q     <= 1'b1;
      lvl_q      <= 3'd0;
      spur_q     <= 1'b0;
      entry_q    <= 1'b0;
      chosen_q   <= 8'h00;
      isr_q      <= 8'h00;
      int_q      <= 1'b0;
      data_oe_q  <= 1'b0;
      data_out_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      inta_q     <= INTA_n;
      lvl_q      <= lvl_d;
      spur_q     <= spur_d;
      entry_q    <= entry_d;
      chosen_q   <= chosen_d;
      isr_q      <= isr_d;
      int_q      <= int_d;
      data_oe_q  <= data_oe_d;
      data_out_q <= data_out_d;
    end
  end

  assign INT      = int_q;
  assign chosen   = chosen_q;
  assign ISR      = isr_q;
  assign data_oe  = data_oe_q;
  assign data_out = data_out_q;

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// Bench for pic_inta_sequencer: directed scenarios with literal expectations,
// then randomized traffic, with every cycle compared against a handshake-level
// reference model.

module tb_pic_inta_sequencer;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] IRR;
  logic [7:0] IMR;
  logic       INTA_n;
  logic [4:0] vector_base;
  logic       eoi_ns;
  logic       eoi_sp;
  logic [2:0] eoi_level;
`ifdef PIC_AUTO_EOI_EN
  logic       aeoi;
`endif
  logic       INT;
  logic [7:0] chosen;
  logic [7:0] ISR;
  logic [7:0] data_out;
  logic       data_oe;

  pic_inta_sequencer dut (
    .CLK         (CLK),
    .RST         (RST),
    .IRR         (IRR),
    .IMR         (IMR),
    .INTA_n      (INTA_n),
    .vector_base (vector_base),
    .eoi_ns      (eoi_ns),
    .eoi_sp      (eoi_sp),
    .eoi_level   (eoi_level),
`ifdef PIC_AUTO_EOI_EN
    .aeoi        (aeoi),
`endif
    .INT         (INT),
    .chosen      (chosen),
    .ISR         (ISR),
    .data_out    (data_out),
    .data_oe     (data_oe)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  logic rand_mode = 1'b0;

  // Reference model: handshake phase 0 none, 1 first low, 2 between, 3 second low.
  int         hs;
  logic       m_req, m_spur, m_set_next, m_inta;
  logic [2:0] m_lvl;
  logic [7:0] m_isr;
  logic       exp_int, exp_oe;
  logic [7:0] exp_chosen, exp_out;

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 8;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hs = 0; m_req = 0; m_spur = 0; m_set_next = 0; m_inta = 1;
    m_lvl = 0; m_isr = 0;
    exp_int = 0; exp_oe = 0; exp_chosen = 0; exp_out = 0;
  endtask

  task automatic model_step();
    logic [7:0] pend, nisr;
    int rl, il;
    logic fall, rise, was_req, elig;
    if (RST) begin
      model_reset();
      return;
    end
    pend = IRR & ~IMR;
    rl   = lowest(pend);
    il   = lowest(m_isr);
    elig = (pend != 0) && (rl < il);
    fall = m_inta && !INTA_n;
    rise = !m_inta && INTA_n;
    nisr = m_isr;
    if (eoi_sp) nisr[eoi_level] = 1'b0;
    else if (eoi_ns && il < 8) nisr[il] = 1'b0;
`ifdef PIC_AUTO_EOI_EN
    if (aeoi && hs == 3 && rise) nisr[m_lvl] = 1'b0;
`endif
    exp_chosen = 8'h00;
    if (m_set_next && !m_spur) begin
      exp_chosen[m_lvl] = 1'b1;
      nisr[m_lvl] = 1'b1;
    end
    m_set_next = 0;
    exp_oe  = (hs == 3);
    exp_out = exp_oe ? {vector_base, m_lvl} : 8'h00;
    was_req = m_req;
    case (hs)
      0: begin
        if (fall) begin
          hs = 1; m_req = 0; m_set_next = 1;
          m_spur = (pend == 0);
          m_lvl  = (pend == 0) ? 3'd7 : 3'(rl);
        end else begin
          m_req = elig;
        end
      end
      1: if (rise) hs = 2;
      2: if (fall) hs = 3;
      default: if (rise) hs = 0;
    endcase
    exp_int = was_req && m_req;
    m_isr   = nisr;
    m_inta  = INTA_n;
  endtask

  task automatic compare_all();
    chk("int", {7'd0, INT}, {7'd0, exp_int});
    chk("chosen", chosen, exp_chosen);
    chk("isr", ISR, m_isr);
    chk("data_oe", {7'd0, data_oe}, {7'd0, exp_oe});
    chk("data_out", data_out, exp_out);
  endtask

  task automatic rand_inputs();
    if ($urandom_range(0, 3) == 0) IRR = IRR | (8'd1 << $urandom_range(0, 7));
    IRR = IRR & ~exp_chosen;
    if ($urandom_range(0, 9) == 0) IRR = 8'h00;
    if ($urandom_range(0, 15) == 0) IMR = 8'($urandom) & 8'($urandom);
    eoi_ns    = ($urandom_range(0, 9) == 0);
    eoi_sp    = ($urandom_range(0, 11) == 0);
    eoi_level = 3'($urandom_range(0, 7));
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic tick();
    if (rand_mode) rand_inputs();
    @(negedge CLK);
    compare_all();
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic ack(input int lo1, input int hi, input int lo2,
                     output logic [7:0] ch, output logic [7:0] vec, output logic saw_oe);
    ch = 0; vec = 0; saw_oe = 0;
    INTA_n = 1'b0;
    repeat (lo1) begin tick(); ch |= chosen; end
    INTA_n = 1'b1;
    repeat (hi) begin tick(); ch |= chosen; end
    INTA_n = 1'b0;
    repeat (lo2) begin tick(); if (data_oe) begin vec = data_out; saw_oe = 1; end end
    INTA_n = 1'b1;
    repeat (2) begin tick(); if (data_oe) begin vec = data_out; saw_oe = 1; end end
  endtask

  initial begin
    logic [7:0] ch, vec;
    logic       soe;
    IRR = 0; IMR = 0; INTA_n = 1; vector_base = 5'b01000;
    eoi_ns = 0; eoi_sp = 0; eoi_level = 0; RST = 0;
`ifdef PIC_AUTO_EOI_EN
    aeoi = 0;
`endif
    #2 RST = 1;
    model_reset();
    tick(); tick();
    chk("rst_int", {7'd0, INT}, 8'd0);
    chk("rst_isr", ISR, 8'd0);
    chk("rst_oe", {7'd0, data_oe}, 8'd0);
    RST = 0;
    tick();

    // Basic handshake
    IRR = 8'b00100100;
    tick(); chk("basic_int_lat1", {7'd0, INT}, 8'd0);
    tick(); chk("basic_int_lat2", {7'd0, INT}, 8'd1);
    INTA_n = 0;
    tick(); chk("basic_int_drop", {7'd0, INT}, 8'd0);
    tick(); chk("basic_chosen", chosen, 8'b00000100);
    chk("basic_isr", ISR, 8'b00000100);
    IRR = 8'b00100000;
    INTA_n = 1;
    tick(); chk("basic_chosen_pulse", chosen, 8'd0);
    INTA_n = 0;
    tick(); tick();
    chk("basic_oe", {7'd0, data_oe}, 8'd1);
    chk("basic_vec", data_out, 8'h42);
    INTA_n = 1;
    tick(); chk("basic_oe_hold", {7'd0, data_oe}, 8'd1);
    tick(); chk("basic_oe_off", {7'd0, data_oe}, 8'd0);
    chk("basic_out_off", data_out, 8'h00);

    // Nesting
    IRR = 8'b00001000;
    tick(); tick(); tick();
    chk("nest_blocked", {7'd0, INT}, 8'd0);
    IRR = 8'b00001010;
    tick(); tick();
    chk("nest_int", {7'd0, INT}, 8'd1);
    ack(2, 1, 2, ch, vec, soe);
    chk("nest_chosen", ch, 8'b00000010);
    chk("nest_vec", vec, 8'h41);
    chk("nest_isr", ISR, 8'b00000110);
    IRR = 8'b00001000;

    // EOI
    eoi_ns = 1; tick(); eoi_ns = 0;
    chk("eoi_ns", ISR, 8'b00000100);
    eoi_sp = 1; eoi_level = 2; tick(); eoi_sp = 0;
    chk("eoi_sp", ISR, 8'b00000000);
    tick(); tick();
    chk("eoi_req_int", {7'd0, INT}, 8'd1);
    ack(3, 2, 2, ch, vec, soe);
    chk("eoi_ack_isr", ISR, 8'b00001000);
    IRR = 0;
    eoi_ns = 1; eoi_sp = 1; eoi_level = 5; tick(); eoi_ns = 0; eoi_sp = 0;
    chk("eoi_both", ISR, 8'b00001000);
    eoi_ns = 1; tick(); eoi_ns = 0;
    chk("eoi_ns_last", ISR, 8'b00000000);

    // Spurious
    IRR = 8'b00001000;
    tick(); tick();
    chk("spur_int", {7'd0, INT}, 8'd1);
    IRR = 0;
    tick(); chk("spur_int_drop", {7'd0, INT}, 8'd0);
    ack(2, 1, 3, ch, vec, soe);
    chk("spur_chosen", ch, 8'd0);
    chk("spur_vec", vec, 8'h47);
    chk("spur_oe_seen", {7'd0, soe}, 8'd1);
    chk("spur_isr", ISR, 8'd0);

    // Reset in GAP
    IRR = 8'b00000001;
    tick(); tick();
    INTA_n = 0; tick(); tick();
    INTA_n = 1; tick(); tick();
    chk("gap_isr_before", ISR, 8'b00000001);
    RST = 1;
    model_reset();
    #1;
    chk("gap_rst_isr", ISR, 8'd0);
    chk("gap_rst_int", {7'd0, INT}, 8'd0);
    chk("gap_rst_chosen", chosen, 8'd0);
    chk("gap_rst_oe", {7'd0, data_oe}, 8'd0);
    chk("gap_rst_out", data_out, 8'd0);
    tick();
    RST = 0;
    ack(2, 1, 2, ch, vec, soe);
    chk("restart_chosen", ch, 8'b00000001);
    chk("restart_vec", vec, 8'h40);
    chk("restart_isr", ISR, 8'b00000001);
    IRR = 0;
    eoi_sp = 1; eoi_level = 0; tick(); eoi_sp = 0;

`ifdef PIC_AUTO_EOI_EN
    // Auto-EOI
    aeoi = 1; IRR = 8'b00000001;
    tick(); tick();
    ack(2, 1, 2, ch, vec, soe);
    chk("aeoi_chosen", ch, 8'b00000001);
    chk("aeoi_isr", ISR, 8'd0);
    tick();
    chk("aeoi_reint", {7'd0, INT}, 8'd1);
    aeoi = 0; IRR = 0;
    tick(); tick();
`endif

    // Randomized traffic
    rand_mode = 1;
    repeat (200) begin
      repeat ($urandom_range(0, 4)) tick();
      vector_base = 5'($urandom);
`ifdef PIC_AUTO_EOI_EN
      aeoi = 1'($urandom_range(0, 1));
`endif
      ack($urandom_range(2, 4), $urandom_range(1, 3), $urandom_range(2, 4), ch, vec, soe);
    end
    rand_mode = 0;
    eoi_ns = 0; eoi_sp = 0; IRR = 0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
